// File: rtl/rom_rr_read_model.sv
// rtl/rom_rr_read_model.sv - round-robin multi-channel constant-table read model
//
// Purpose: serves NUM_CH read requesters from one fixed table
//   mem[i] = (i*29 + 9) mod 2^WR_DATA_WD, 0 <= i < DATA_DEPTH.
//   A round-robin arbiter grants one request per cycle. Each accepted read
//   returns RD_LAT cycles later, tagged with its channel and an
//   out-of-range flag.
// Optional feature macro: ROM_PARITY_EN (adds rd_parity = ^rd_data).
//
// Ports:
//   clk             - rising-edge clock
//   reset_n         - asynchronous active-low reset
//   rd_vld          - per-channel request valid
//   rd_addr         - per-channel address, channel k at [k*WR_ADDR_WD +: WR_ADDR_WD]
//   rd_rdy          - per-channel grant, one-hot or zero
//   rd_data         - response data (0 when not valid)
//   rd_data_out_vld - response valid, one cycle per response
//   rd_data_ch      - channel tag of the response (0 when not valid)
//   rd_oob          - response address was >= DATA_DEPTH (0 when not valid)
//   rd_parity       - even parity of rd_data (ROM_PARITY_EN only)
module rom_rr_read_model #(
  parameter  int WR_ADDR_WD = 8,
  parameter  int WR_DATA_WD = 8,
  parameter  int DATA_DEPTH = 48,
  parameter  int NUM_CH     = 2,
  parameter  int RD_LAT     = 2,
  localparam int CH_WD      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            rd_vld,
  input  logic [NUM_CH*WR_ADDR_WD-1:0] rd_addr,
  output logic [NUM_CH-1:0]            rd_rdy,
  output logic [WR_DATA_WD-1:0]        rd_data,
  output logic                         rd_data_out_vld,
  output logic [CH_WD-1:0]             rd_data_ch,
  output logic                         rd_oob
`ifdef ROM_PARITY_EN
  ,
  output logic                         rd_parity
`endif
);

  function automatic logic [WR_DATA_WD-1:0] rom_word(input logic [WR_ADDR_WD-1:0] a);
    return WR_DATA_WD'(64'(a) * 64'd29 + 64'd9);
  endfunction

  logic [CH_WD-1:0]      ptr_q, ptr_d;
  logic [CH_WD-1:0]      gnt_idx;
  logic                  gnt_found;
  logic                  accept;
  logic [NUM_CH-1:0]     gnt;
  logic [WR_ADDR_WD-1:0] sel_addr;
  logic                  in_range;
  int                    arb_idx;
  int                    nxt_ptr;

  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [RD_LAT-1:0]     oob_q, oob_d;
  logic [RD_LAT-1:0]     par_q, par_d;
  logic [WR_DATA_WD-1:0] data_q [RD_LAT];
  logic [WR_DATA_WD-1:0] data_d [RD_LAT];
  logic [CH_WD-1:0]      ch_q   [RD_LAT];
  logic [CH_WD-1:0]      ch_d   [RD_LAT];

  // Search starts at ptr and wraps; the first requesting channel wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (!gnt_found && rd_vld[arb_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_WD'(arb_idx);
      end
    end
  end

  // Grants are suppressed during reset so nothing can be accepted then.
  assign accept = gnt_found & reset_n;

  always_comb begin
    gnt = '0;
    if (accept) gnt[gnt_idx] = 1'b1;
  end
  assign rd_rdy = gnt;

  assign sel_addr = rd_addr[int'(gnt_idx)*WR_ADDR_WD +: WR_ADDR_WD];
  assign in_range = (64'(sel_addr) < 64'(DATA_DEPTH));

  always_comb begin
    ptr_d   = ptr_q;
    nxt_ptr = int'(gnt_idx) + 1;
    if (nxt_ptr >= NUM_CH) nxt_ptr = 0;
    if (accept) ptr_d = CH_WD'(nxt_ptr);
  end

  // Stage payloads are zeroed when a slot is empty, so the output stage
  // already reads 0 whenever it carries no response.
  always_comb begin
    vld_d[0]  = accept;
    oob_d[0]  = accept & ~in_range;
    data_d[0] = (accept && in_range) ? rom_word(sel_addr) : '0;
    par_d[0]  = ^data_d[0];
    ch_d[0]   = accept ? gnt_idx : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      oob_d[i]  = oob_q[i-1];
      par_d[i]  = par_q[i-1];
      data_d[i] = data_q[i-1];
      ch_d[i]   = ch_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      vld_q <= '0;
      oob_q <= '0;
      par_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= '0;
        ch_q[i]   <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      oob_q <= oob_d;
      par_q <= par_d;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= data_d[i];
        ch_q[i]   <= ch_d[i];
      end
    end
  end

  assign rd_data_out_vld = vld_q[RD_LAT-1];
  assign rd_data         = data_q[RD_LAT-1];
  assign rd_data_ch      = ch_q[RD_LAT-1];
  assign rd_oob          = oob_q[RD_LAT-1];
`ifdef ROM_PARITY_EN
  assign rd_parity       = par_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_rom_rr_read_model.sv
// tb/tb_rom_rr_read_model.sv - directed self-checking bench for rom_rr_read_model
module tb_rom_rr_read_model;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [1:0]  rd_vld;
  logic [15:0] rd_addr;
  logic [1:0]  rd_rdy;
  logic [7:0]  rd_data;
  logic        rd_data_out_vld;
  logic        rd_data_ch;
  logic        rd_oob;

  logic [3:0]  rd_vld4;
  logic [31:0] rd_addr4;
  logic [3:0]  rd_rdy4;
  logic [7:0]  rd_data4;
  logic        rd_data_out_vld4;
  logic [1:0]  rd_data_ch4;
  logic        rd_oob4;
`ifdef ROM_PARITY_EN
  logic        rd_parity;
  logic        rd_parity4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rom_rr_read_model u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd_vld          (rd_vld),
    .rd_addr         (rd_addr),
    .rd_rdy          (rd_rdy),
    .rd_data         (rd_data),
    .rd_data_out_vld (rd_data_out_vld),
    .rd_data_ch      (rd_data_ch),
    .rd_oob          (rd_oob)
`ifdef ROM_PARITY_EN
    ,
    .rd_parity       (rd_parity)
`endif
  );

  rom_rr_read_model #(.NUM_CH(4), .RD_LAT(4)) u_dut4 (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd_vld          (rd_vld4),
    .rd_addr         (rd_addr4),
    .rd_rdy          (rd_rdy4),
    .rd_data         (rd_data4),
    .rd_data_out_vld (rd_data_out_vld4),
    .rd_data_ch      (rd_data_ch4),
    .rd_oob          (rd_oob4)
`ifdef ROM_PARITY_EN
    ,
    .rd_parity       (rd_parity4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic ev, input logic [7:0] ed,
                            input logic ech, input logic eoob);
    check({tag, "_vld"}, 32'(rd_data_out_vld), 32'(ev));
    check({tag, "_data"}, 32'(rd_data), 32'(ed));
    check({tag, "_ch"}, 32'(rd_data_ch), 32'(ech));
    check({tag, "_oob"}, 32'(rd_oob), 32'(eoob));
`ifdef ROM_PARITY_EN
    check({tag, "_par"}, 32'(rd_parity), 32'(^ed));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tbl4 [4];

  initial begin
    tbl4 = '{8'd9, 8'd38, 8'd67, 8'd96};
    rd_vld = '0; rd_addr = '0; rd_vld4 = '0; rd_addr4 = '0;

    // Reset state: grants forced low even with requests pending.
    #1;
    rd_vld = 2'b11;
    #1;
    check("rst_rdy", 32'(rd_rdy), 32'd0);
    check_resp("rst", 1'b0, 8'd0, 1'b0, 1'b0);
    rd_vld = 2'b00;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // Single request ch0 addr 1 -> 38 two cycles later, one cycle only.
    rd_vld = 2'b01; rd_addr = {8'd0, 8'd1};
    #1 check("t1_rdy", 32'(rd_rdy), 32'd1);
    step(); rd_vld = 2'b00;
    check_resp("t1_c1", 1'b0, 8'd0, 1'b0, 1'b0);
    step(); check_resp("t1_c2", 1'b1, 8'd38, 1'b0, 1'b0);
    step(); check_resp("t1_c3", 1'b0, 8'd0, 1'b0, 1'b0);

    // Boundary: ch1 addr 47 in range, addr 48 out of range.
    rd_vld = 2'b10; rd_addr = {8'd47, 8'd0};
    #1 check("bd_rdy0", 32'(rd_rdy), 32'd2);
    step(); rd_addr = {8'd48, 8'd0};
    #1 check("bd_rdy1", 32'(rd_rdy), 32'd2);
    step(); rd_vld = 2'b00;
    check_resp("bd_47", 1'b1, 8'd92, 1'b1, 1'b0);
    step(); check_resp("bd_48", 1'b1, 8'd0, 1'b1, 1'b1);
    step(); check_resp("bd_end", 1'b0, 8'd0, 1'b0, 1'b0);

    // Both channels requesting continuously: grants alternate from ch0.
    rd_vld = 2'b11; rd_addr = {8'd5, 8'd2};
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("t2_k%0d_rdy", k), 32'(rd_rdy), (k % 2 == 1) ? 32'd2 : 32'd1);
      check($sformatf("t2_k%0d_hot", k), 32'($countones(rd_rdy)), 32'd1);
      if (k >= 2)
        check_resp($sformatf("t2_k%0d", k), 1'b1, (k % 2 == 1) ? 8'd154 : 8'd67,
                   (k % 2 == 1), 1'b0);
      else
        check_resp($sformatf("t2_k%0d", k), 1'b0, 8'd0, 1'b0, 1'b0);
      step();
    end
    rd_vld = 2'b00;
    check_resp("t2_d0", 1'b1, 8'd67, 1'b0, 1'b0);
    step(); check_resp("t2_d1", 1'b1, 8'd154, 1'b1, 1'b0);
    step(); check_resp("t2_d2", 1'b0, 8'd0, 1'b0, 1'b0);

    // Reset with responses in flight.
    rd_vld = 2'b11; rd_addr = {8'd4, 8'd3};
    #1 check("rr_rdy0", 32'(rd_rdy), 32'd1);
    step();
    #1 check("rr_rdy1", 32'(rd_rdy), 32'd2);
    step(); rd_vld = 2'b00;
    check_resp("rr_first", 1'b1, 8'd96, 1'b0, 1'b0);
    reset_n = 1'b0; rd_vld = 2'b11;
    #1;
    check_resp("rr_async", 1'b0, 8'd0, 1'b0, 1'b0);
    check("rr_rdy_rst", 32'(rd_rdy), 32'd0);
    step(); check_resp("rr_held", 1'b0, 8'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    check("rr_rdy_rel", 32'(rd_rdy), 32'd1);
    check_resp("rr_rel", 1'b0, 8'd0, 1'b0, 1'b0);
    step(); rd_vld = 2'b00;
    check_resp("rr_noghost", 1'b0, 8'd0, 1'b0, 1'b0);
    step(); check_resp("rr_new", 1'b1, 8'd96, 1'b0, 1'b0);
    step(); check_resp("rr_end", 1'b0, 8'd0, 1'b0, 1'b0);

    // Four channels, latency 4: grants ch0..ch3, responses 9,38,67,96.
    rd_addr4 = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int k = 0; k < 9; k++) begin
      rd_vld4 = 4'b1111 << k;
      #1;
      check($sformatf("q4_k%0d_rdy", k), 32'(rd_rdy4), (k < 4) ? (32'd1 << k) : 32'd0);
      if (k >= 4 && k < 8) begin
        check($sformatf("q4_k%0d_vld", k), 32'(rd_data_out_vld4), 32'd1);
        check($sformatf("q4_k%0d_data", k), 32'(rd_data4), 32'(tbl4[k-4]));
        check($sformatf("q4_k%0d_ch", k), 32'(rd_data_ch4), 32'(k - 4));
        check($sformatf("q4_k%0d_oob", k), 32'(rd_oob4), 32'd0);
`ifdef ROM_PARITY_EN
        check($sformatf("q4_k%0d_par", k), 32'(rd_parity4), 32'(^tbl4[k-4]));
`endif
      end else begin
        check($sformatf("q4_k%0d_vld", k), 32'(rd_data_out_vld4), 32'd0);
        check($sformatf("q4_k%0d_data", k), 32'(rd_data4), 32'd0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
